// File: rtl/acq_control_pkg.sv
// Shared definitions for the acquisition controller: state encoding,
// stop-reason codes and the default data/address widths.
package acq_control_pkg;

    localparam int DEF_BITS      = 8;
    localparam int DEF_ADDR_BITS = 19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_ACQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } acq_state_t;

    localparam logic [1:0] STOP_NONE  = 2'b00;
    localparam logic [1:0] STOP_INDEX = 2'b01;
    localparam logic [1:0] STOP_FULL  = 2'b10;
    localparam logic [1:0] STOP_ABORT = 2'b11;

    // Reader writes are forwarded to RAM only in these states.
    function automatic logic in_capture_window(input acq_state_t s);
        return (s == ST_ACQ) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/acq_control_if.sv
// Control, reader and RAM-write signals of the acquisition controller.
// The slave side is the controller; the master side drives it.
interface acq_control_if #(
    parameter int BITS      = acq_control_pkg::DEF_BITS,
    parameter int ADDR_BITS = acq_control_pkg::DEF_ADDR_BITS
);
    logic                 START;
    logic                 ABORT;
    logic                 WAIT_INDEX;
    logic [7:0]           STOP_INDEX_COUNT;
    logic                 INDEX_IN;
    logic [BITS-1:0]      MDR_DATA;
    logic                 MDR_WRITE;
    logic                 MDR_RUN;
    logic [ADDR_BITS-1:0] RAM_ADDR;
    logic [BITS-1:0]      RAM_DATA;
    logic                 RAM_WR;
    logic                 BUSY;
    logic                 WAITING;
    logic [1:0]           STOP_REASON;

    modport master (
        output START, ABORT, WAIT_INDEX, STOP_INDEX_COUNT, INDEX_IN,
               MDR_DATA, MDR_WRITE,
        input  MDR_RUN, RAM_ADDR, RAM_DATA, RAM_WR, BUSY, WAITING,
               STOP_REASON
    );

    modport slave (
        input  START, ABORT, WAIT_INDEX, STOP_INDEX_COUNT, INDEX_IN,
               MDR_DATA, MDR_WRITE,
        output MDR_RUN, RAM_ADDR, RAM_DATA, RAM_WR, BUSY, WAITING,
               STOP_REASON
    );
endinterface

// File: rtl/acq_control_index_edge_detect.sv
// Rising-edge detector for the (already synchronised) index level.
module index_edge_detect (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic level,
    output logic rise
);
    logic prev_q;

    // Remember last cycle's level.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) prev_q <= 1'b0;
        else          prev_q <= level;
    end

    assign rise = level & ~prev_q;
endmodule

// File: rtl/acq_control.sv
// Acquisition controller: arms on START, optionally waits for an index
// edge, streams disc-reader words into RAM, and stops on index count,
// RAM full or ABORT, with a short drain to catch in-flight reader writes.
module acq_control #(
    parameter int BITS      = acq_control_pkg::DEF_BITS,
    parameter int ADDR_BITS = acq_control_pkg::DEF_ADDR_BITS
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    acq_control_if.slave  bus
);
    import acq_control_pkg::*;

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

    acq_state_t           state_q, state_d;
    logic [1:0]           reason_q, reason_d;
    logic [7:0]           idx_cnt_q, idx_cnt_d, idx_cnt_inc;
    logic                 drain_q, drain_d;
    logic                 full_q;
    logic                 ready_q;
    logic                 run_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 vld_p1;
    logic [BITS-1:0]      data_p1;

    logic                 idx_rise;
    logic                 start_ok;
    logic                 full_hit;
    logic                 full_now;
    logic                 capture;

    index_edge_detect u_index_edge (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .level   (bus.INDEX_IN),
        .rise    (idx_rise)
    );

    // A write to the last address is in flight this cycle: the RAM becomes
    // full at the next edge, so no further word may be accepted now.
    assign full_hit    = vld_p1 && (addr_q == ADDR_MAX);
    assign full_now    = full_q || full_hit;
    assign idx_cnt_inc = idx_cnt_q + 8'd1;
    assign start_ok    = bus.START && !bus.ABORT && ready_q &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign capture     = in_capture_window(state_q) && bus.MDR_WRITE && !full_now;

    // State register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state, stop reason, index counter and drain timer.
    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        idx_cnt_d = idx_cnt_q;
        drain_d   = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    reason_d  = STOP_NONE;
                    idx_cnt_d = 8'd0;
                    state_d   = bus.WAIT_INDEX ? ST_ARMED : ST_ACQ;
                end
            end
            ST_ARMED: begin
                if (bus.ABORT) begin
                    reason_d = STOP_ABORT;
                    state_d  = ST_DONE;
                end else if (idx_rise) begin
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (bus.ABORT) begin
                    reason_d = STOP_ABORT;
                    state_d  = ST_DONE;
                end else begin
                    if (idx_rise) idx_cnt_d = idx_cnt_inc;
                    // Full outranks an index stop landing in the same cycle.
                    if (full_hit) begin
                        reason_d = STOP_FULL;
                        state_d  = ST_DRAIN;
                        drain_d  = 1'b0;
                    end else if (idx_rise && (bus.STOP_INDEX_COUNT != 8'd0) &&
                                 (idx_cnt_inc == bus.STOP_INDEX_COUNT)) begin
                        reason_d = STOP_INDEX;
                        state_d  = ST_DRAIN;
                        drain_d  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.ABORT) begin
                    reason_d = STOP_ABORT;
                    state_d  = ST_DONE;
                end else if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers: run enable, stop reason, counters, full flag and
    // the one-cycle post-reset hold-off on START.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            run_q     <= 1'b0;
            reason_q  <= STOP_NONE;
            idx_cnt_q <= 8'd0;
            drain_q   <= 1'b0;
            full_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            run_q     <= (state_d == ST_ACQ);
            reason_q  <= reason_d;
            idx_cnt_q <= idx_cnt_d;
            drain_q   <= drain_d;
            ready_q   <= 1'b1;
            if (start_ok)      full_q <= 1'b0;
            else if (full_hit) full_q <= 1'b1;
        end
    end

    // Stage p1: reader word registered onto the RAM write port.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= capture;
            if (capture) data_p1 <= bus.MDR_DATA;
        end
    end

    // Write address: advances after each write, parks on the last address.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)                 addr_q <= '0;
        else if (start_ok)            addr_q <= '0;
        else if (vld_p1 && !full_hit) addr_q <= addr_q + 1'b1;
    end

    assign bus.MDR_RUN     = run_q;
    assign bus.RAM_WR      = vld_p1;
    assign bus.RAM_DATA    = data_p1;
    assign bus.RAM_ADDR    = addr_q;
    assign bus.STOP_REASON = reason_q;
    assign bus.BUSY        = (state_q != ST_IDLE);
    assign bus.WAITING     = (state_q == ST_ARMED);
endmodule

// File: tb/tb_acq_control.sv
// Directed bench for acq_control with a 4-bit address space.
module tb_acq_control;
    import acq_control_pkg::*;

    logic CLOCK;
    logic RESET_N;
    int   checks = 0;
    int   errors = 0;

    acq_control_if #(.BITS(8), .ADDR_BITS(4)) bus ();

    acq_control #(.BITS(8), .ADDR_BITS(4)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        RESET_N              = 1'b0;
        bus.START            = 1'b0;
        bus.ABORT            = 1'b0;
        bus.WAIT_INDEX       = 1'b0;
        bus.STOP_INDEX_COUNT = 8'd2;
        bus.INDEX_IN         = 1'b0;
        bus.MDR_DATA         = 8'h00;
        bus.MDR_WRITE        = 1'b0;
        repeat (3) tick();

        check("rst_run",    32'(bus.MDR_RUN), 32'd0);
        check("rst_wr",     32'(bus.RAM_WR), 32'd0);
        check("rst_addr",   32'(bus.RAM_ADDR), 32'd0);
        check("rst_data",   32'(bus.RAM_DATA), 32'd0);
        check("rst_reason", 32'(bus.STOP_REASON), 32'd0);
        check("rst_busy",   32'(bus.BUSY), 32'd0);
        check("rst_wait",   32'(bus.WAITING), 32'd0);

        // Release reset; START on the first edge is ignored, second accepted.
        RESET_N   = 1'b1;
        bus.START = 1'b1;
        tick();
        check("start_edge1_ignored", 32'(bus.BUSY), 32'd0);
        tick();
        bus.START = 1'b0;
        check("start_edge2_busy", 32'(bus.BUSY), 32'd1);
        check("start_edge2_run",  32'(bus.MDR_RUN), 32'd1);
        check("start_edge2_wait", 32'(bus.WAITING), 32'd0);

        // Five back-to-back reader writes.
        for (int i = 0; i < 5; i++) begin
            bus.MDR_WRITE = 1'b1;
            bus.MDR_DATA  = 8'hA0 + 8'(i);
            tick();
            check("wr5_wr",   32'(bus.RAM_WR), 32'd1);
            check("wr5_data", 32'(bus.RAM_DATA), 32'hA0 + 32'(i));
            check("wr5_addr", 32'(bus.RAM_ADDR), 32'(i));
        end
        bus.MDR_WRITE = 1'b0;
        tick();
        check("wr5_idle_wr",   32'(bus.RAM_WR), 32'd0);
        check("wr5_idle_addr", 32'(bus.RAM_ADDR), 32'd5);

        // Two index edges with STOP_INDEX_COUNT=2.
        bus.INDEX_IN = 1'b1;
        tick();
        check("idx1_run", 32'(bus.MDR_RUN), 32'd1);
        bus.INDEX_IN = 1'b0;
        tick();
        bus.INDEX_IN = 1'b1;
        tick();
        check("idx2_run",    32'(bus.MDR_RUN), 32'd0);
        check("idx2_reason", 32'(bus.STOP_REASON), 32'(STOP_INDEX));
        check("idx2_drain",  32'(dut.state_q), 32'(ST_DRAIN));
        bus.INDEX_IN = 1'b0;
        tick();
        check("drain2", 32'(dut.state_q), 32'(ST_DRAIN));
        tick();
        check("idx_done",        32'(dut.state_q), 32'(ST_DONE));
        check("idx_done_busy",   32'(bus.BUSY), 32'd1);
        tick();
        check("idx_hold_reason", 32'(bus.STOP_REASON), 32'(STOP_INDEX));
        check("idx_hold_addr",   32'(bus.RAM_ADDR), 32'd5);

        // Write on the second DRAIN cycle is still captured.
        bus.STOP_INDEX_COUNT = 8'd1;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("restart_reason", 32'(bus.STOP_REASON), 32'd0);
        check("restart_addr",   32'(bus.RAM_ADDR), 32'd0);
        bus.INDEX_IN = 1'b1;
        tick();
        bus.INDEX_IN = 1'b0;
        check("d2_enter", 32'(dut.state_q), 32'(ST_DRAIN));
        tick();
        check("d2_second", 32'(dut.state_q), 32'(ST_DRAIN));
        check("d2_pre_wr", 32'(bus.RAM_WR), 32'd0);
        bus.MDR_WRITE = 1'b1;
        bus.MDR_DATA  = 8'h5A;
        tick();
        check("d2_wr",   32'(bus.RAM_WR), 32'd1);
        check("d2_data", 32'(bus.RAM_DATA), 32'h5A);
        check("d2_addr", 32'(bus.RAM_ADDR), 32'd0);
        check("d2_done", 32'(dut.state_q), 32'(ST_DONE));
        tick();
        bus.MDR_WRITE = 1'b0;
        check("done_drop_wr", 32'(bus.RAM_WR), 32'd0);
        check("done_addr",    32'(bus.RAM_ADDR), 32'd1);

        // Wait for index: writes before the arming edge are ignored.
        bus.WAIT_INDEX       = 1'b1;
        bus.STOP_INDEX_COUNT = 8'd2;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("armed_wait", 32'(bus.WAITING), 32'd1);
        check("armed_run",  32'(bus.MDR_RUN), 32'd0);
        check("armed_busy", 32'(bus.BUSY), 32'd1);
        bus.MDR_WRITE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.MDR_DATA = 8'(i);
            tick();
            check("armed_no_wr", 32'(bus.RAM_WR), 32'd0);
        end
        bus.MDR_WRITE = 1'b0;
        bus.INDEX_IN  = 1'b1;
        tick();
        check("arm_edge_run",  32'(bus.MDR_RUN), 32'd1);
        check("arm_edge_wait", 32'(bus.WAITING), 32'd0);
        check("arm_edge_wr",   32'(bus.RAM_WR), 32'd0);
        bus.INDEX_IN = 1'b0;
        tick();
        bus.INDEX_IN = 1'b1;
        tick();
        bus.INDEX_IN = 1'b0;
        check("arm_edge_not_counted", 32'(bus.MDR_RUN), 32'd1);

        // ABORT together with START in ACQ.
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        check("abort_done",   32'(dut.state_q), 32'(ST_DONE));
        check("abort_reason", 32'(bus.STOP_REASON), 32'(STOP_ABORT));
        check("abort_run",    32'(bus.MDR_RUN), 32'd0);
        tick();
        check("abort_hold_state",  32'(dut.state_q), 32'(ST_DONE));
        check("abort_hold_reason", 32'(bus.STOP_REASON), 32'(STOP_ABORT));

        // Continuous writes fill the 16-entry RAM.
        bus.WAIT_INDEX       = 1'b0;
        bus.STOP_INDEX_COUNT = 8'd0;
        bus.START = 1'b1;
        tick();
        bus.START     = 1'b0;
        bus.MDR_WRITE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.MDR_DATA = 8'(3 * i + 1);
            tick();
            check("fill_wr",   32'(bus.RAM_WR), 32'd1);
            check("fill_addr", 32'(bus.RAM_ADDR), 32'(i));
            check("fill_data", 32'(bus.RAM_DATA), 32'(3 * i + 1));
        end
        tick();
        check("full_no17_wr", 32'(bus.RAM_WR), 32'd0);
        check("full_addr",    32'(bus.RAM_ADDR), 32'd15);
        check("full_reason",  32'(bus.STOP_REASON), 32'(STOP_FULL));
        check("full_run",     32'(bus.MDR_RUN), 32'd0);
        tick();
        check("full_drain_wr", 32'(bus.RAM_WR), 32'd0);
        tick();
        check("full_done",      32'(dut.state_q), 32'(ST_DONE));
        check("full_done_wr",   32'(bus.RAM_WR), 32'd0);
        check("full_done_addr", 32'(bus.RAM_ADDR), 32'd15);
        bus.MDR_WRITE = 1'b0;

        // Reset in the middle of an acquisition.
        bus.START = 1'b1;
        tick();
        bus.START     = 1'b0;
        bus.MDR_WRITE = 1'b1;
        bus.MDR_DATA  = 8'hC3;
        tick();
        tick();
        check("pre_rst_wr",   32'(bus.RAM_WR), 32'd1);
        check("pre_rst_addr", 32'(bus.RAM_ADDR), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_run",   32'(bus.MDR_RUN), 32'd0);
        check("mid_rst_wr",    32'(bus.RAM_WR), 32'd0);
        check("mid_rst_addr",  32'(bus.RAM_ADDR), 32'd0);
        check("mid_rst_busy",  32'(bus.BUSY), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        tick();
        check("rst_low_wr", 32'(bus.RAM_WR), 32'd0);
        bus.MDR_WRITE = 1'b0;
        RESET_N = 1'b1;
        tick();
        check("post_rst_idle",   32'(bus.BUSY), 32'd0);
        check("post_rst_reason", 32'(bus.STOP_REASON), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
